// File: rtl/perf_counter_ctrl_pkg.sv
// Shared types for the performance-counter block: counter tags, FSM states, and
// helpers that map a tag onto a counter index.
package perf_counter_ctrl_pkg;

   localparam int unsigned CNT_NUM = 12;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned TAG_W   = 8;
   localparam int unsigned IDX_W   = 4;

   localparam logic [TAG_W-1:0] CNT_BASE = 8'h10;

   // Counter tags are word-spaced from CNT_BASE; cnt_ctrl sits just past the last one
   typedef enum logic [TAG_W-1:0] {
      icache_hit  = 8'h10,
      icache_miss = 8'h14,
      dcache_hit  = 8'h18,
      dcache_miss = 8'h1C,
      l2_hit      = 8'h20,
      l2_miss     = 8'h24,
      br_taken    = 8'h28,
      br_mispred  = 8'h2C,
      instr_ret   = 8'h30,
      stall_cyc   = 8'h34,
      load_op     = 8'h38,
      store_op    = 8'h3C,
      cnt_ctrl    = 8'h40
   } counter_addr_t;

   typedef enum logic {
      CNT_IDLE = 1'b0,
      CNT_RESP = 1'b1
   } cnt_state_t;

   function automatic logic [IDX_W-1:0] cnt_index(counter_addr_t a);
      return IDX_W'((TAG_W'(a) - CNT_BASE) >> 2);
   endfunction

   function automatic logic is_cnt_tag(logic [TAG_W-1:0] tag);
      return (tag >= CNT_BASE) &&
             (tag < (CNT_BASE + TAG_W'(4 * CNT_NUM))) &&
             (tag[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/perf_counter_ctrl_counter.sv
// One saturating event counter with a synchronous clear that beats increments.
module perf_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             sat
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   assign sat   = &count_q;
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && inc && !sat) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/perf_counter_ctrl.sv
// Memory-mapped bank of performance counters; decodes the counter window, answers
// hits one cycle later, and passes every other access through to the downstream bus.
module perf_counter_ctrl
   import perf_counter_ctrl_pkg::*;
#(
   parameter int unsigned NUM_CNT = CNT_NUM,
   parameter int unsigned WIDTH   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_CNT-1:0] event_inc,
   input  logic [31:0]        mem_addr,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [31:0]        mem_wdata,
   output logic [31:0]        mem_rdata,
   output logic               mem_resp,
   output logic               read_b,
   output logic               write_b,
   input  logic [31:0]        rdata_b,
   input  logic               resp_b,
   output logic [NUM_CNT-1:0] sat_flags
);

   cnt_state_t        state_q;
   cnt_state_t        state_d;
   logic              enable_q;
   logic              enable_d;
   logic [DATA_W-1:0] rd_buf_q;
   logic [DATA_W-1:0] rd_buf_d;

   logic [TAG_W-1:0]   tag_c;
   logic [IDX_W-1:0]   idx_c;
   logic               is_ctrl_c;
   logic               is_cnt_c;
   logic               hit_c;
   logic               accept_c;
   logic [NUM_CNT-1:0] clr_c;
   logic [WIDTH-1:0]   sel_cnt_c;
   logic [WIDTH-1:0]   cnt_val [NUM_CNT];
   logic               unused_wdata_c;

   assign tag_c          = mem_addr[7:0];
   assign idx_c          = cnt_index(counter_addr_t'(tag_c));
   assign is_ctrl_c      = (tag_c == cnt_ctrl);
   assign is_cnt_c       = is_cnt_tag(tag_c) && (32'(idx_c) < NUM_CNT);
   assign hit_c          = (mem_addr[31:8] == 24'h0) && (is_cnt_c || is_ctrl_c);
   assign accept_c       = (state_q == CNT_IDLE) && hit_c && (mem_read || mem_write);
   assign read_b         = mem_read  & ~hit_c;
   assign write_b        = mem_write & ~hit_c;
   assign unused_wdata_c = ^mem_wdata[31:2];

   // Counter bank
   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      perf_counter #(.WIDTH(WIDTH)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .en    (enable_q),
         .inc   (event_inc[g]),
         .clr   (clr_c[g]),
         .count (cnt_val[g]),
         .sat   (sat_flags[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CNT_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CNT_IDLE: if (accept_c) state_d = CNT_RESP;
         CNT_RESP: state_d = CNT_IDLE;
         default:  state_d = CNT_IDLE;
      endcase
   end

   // Access side effects: read capture, counter clears, enable update
   always_comb begin
      enable_d  = enable_q;
      rd_buf_d  = rd_buf_q;
      clr_c     = '0;
      sel_cnt_c = '0;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
         if (IDX_W'(i) == idx_c) begin
            sel_cnt_c = cnt_val[i];
            if (accept_c && mem_write && !is_ctrl_c) clr_c[i] = 1'b1;
         end
      end
      if (accept_c) begin
         if (mem_write) begin
            rd_buf_d = '0;
            if (is_ctrl_c) begin
               enable_d = mem_wdata[0];
               if (mem_wdata[1]) clr_c = '1;
            end
         end else begin
            rd_buf_d = is_ctrl_c ? DATA_W'(enable_q) : DATA_W'(sel_cnt_c);
         end
      end
   end

   // CPU-side response: registered answer in RESP, quiet on an idle hit, else pass-through
   always_comb begin
      mem_resp  = resp_b;
      mem_rdata = rdata_b;
      if (state_q == CNT_RESP) begin
         mem_resp  = 1'b1;
         mem_rdata = rd_buf_q;
      end else if (hit_c) begin
         mem_resp  = 1'b0;
         mem_rdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enable_q <= 1'b1;
         rd_buf_q <= '0;
      end else begin
         enable_q <= enable_d;
         rd_buf_q <= rd_buf_d;
      end
   end

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Directed scenarios plus a randomized protocol-following host, all checked each cycle
// against a behavioural model of the counter bank.
module tb_perf_counter_ctrl;

   localparam int unsigned NC   = 12;
   localparam int unsigned TB_W = 8;
   localparam int unsigned MAXV = (1 << TB_W) - 1;

   localparam logic [31:0] A_ICH  = 32'h10;
   localparam logic [31:0] A_ICM  = 32'h14;
   localparam logic [31:0] A_DCH  = 32'h18;
   localparam logic [31:0] A_L2H  = 32'h20;
   localparam logic [31:0] A_CTRL = 32'h40;
   localparam logic [7:0]  TAG_LIST [13] = '{8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24,
                                            8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h40};

   logic          clk;
   logic          rst;
   logic [NC-1:0] event_inc;
   logic [31:0]   mem_addr;
   logic          mem_read;
   logic          mem_write;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
   logic          mem_resp;
   logic          read_b;
   logic          write_b;
   logic [31:0]   rdata_b;
   logic          resp_b;
   logic [NC-1:0] sat_flags;

   perf_counter_ctrl #(.NUM_CNT(NC), .WIDTH(TB_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .event_inc (event_inc),
      .mem_addr  (mem_addr),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_resp  (mem_resp),
      .read_b    (read_b),
      .write_b   (write_b),
      .rdata_b   (rdata_b),
      .resp_b    (resp_b),
      .sat_flags (sat_flags)
   );

   always #5 clk = ~clk;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   // Model state: counter values, enable, and a pending response with its data
   int unsigned m_cnt [NC];
   bit          m_en;
   bit          m_pend;
   logic [31:0] m_rdbuf;

   logic          obs_resp;
   logic [31:0]   obs_rdata;
   logic          obs_read_b;
   logic [NC-1:0] obs_sat;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int tag_idx(input logic [31:0] a);
      if (a[31:8] != 24'h0) return -1;
      for (int i = 0; i < 13; i++) if (a[7:0] == TAG_LIST[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NC; i++) m_cnt[i] = 0;
      m_en    = 1'b1;
      m_pend  = 1'b0;
      m_rdbuf = '0;
   endtask

   task automatic model_step(input bit r, input logic [NC-1:0] ev, input int idx,
                             input bit rd, input bit wr, input logic [31:0] wd);
      bit          acc;
      bit          nen;
      bit [NC-1:0] clr;
      if (r) begin
         model_reset();
         return;
      end
      acc = !m_pend && (idx >= 0) && (rd || wr);
      nen = m_en;
      clr = '0;
      if (acc) begin
         if (wr) begin
            m_rdbuf = '0;
            if (idx == 12) begin
               nen = wd[0];
               if (wd[1]) clr = '1;
            end else begin
               clr[idx] = 1'b1;
            end
         end else begin
            m_rdbuf = (idx == 12) ? 32'(m_en) : m_cnt[idx];
         end
      end
      for (int i = 0; i < NC; i++) begin
         if (clr[i]) m_cnt[i] = 0;
         else if (ev[i] && m_en && m_cnt[i] < MAXV) m_cnt[i] = m_cnt[i] + 1;
      end
      m_en   = nen;
      m_pend = acc;
   endtask

   // One clock: drive, check outputs at the falling edge, advance model at the rising edge
   task automatic cycle(input bit r, input logic [NC-1:0] ev, input logic [31:0] a,
                        input bit rd, input bit wr, input logic [31:0] wd,
                        input logic [31:0] rb, input bit rsb);
      int            idx;
      bit            hit;
      logic          e_resp;
      logic [31:0]   e_rdata;
      logic [NC-1:0] e_sat;
      rst = r; event_inc = ev; mem_addr = a; mem_read = rd; mem_write = wr;
      mem_wdata = wd; rdata_b = rb; resp_b = rsb;
      idx = tag_idx(a);
      hit = (idx >= 0);
      @(negedge clk);
      e_resp  = m_pend ? 1'b1 : (hit ? 1'b0 : rsb);
      e_rdata = m_pend ? m_rdbuf : (hit ? 32'h0 : rb);
      for (int i = 0; i < NC; i++) e_sat[i] = (m_cnt[i] == MAXV);
      check_eq("mem_resp",  32'(mem_resp),  32'(e_resp));
      check_eq("mem_rdata", mem_rdata,      e_rdata);
      check_eq("read_b",    32'(read_b),    32'(rd && !hit));
      check_eq("write_b",   32'(write_b),   32'(wr && !hit));
      check_eq("sat_flags", 32'(sat_flags), 32'(e_sat));
      obs_resp   = mem_resp;
      obs_rdata  = mem_rdata;
      obs_read_b = read_b;
      obs_sat    = sat_flags;
      @(posedge clk);
      model_step(r, ev, idx, rd, wr, wd);
      #1;
   endtask

   task automatic idle(input logic [NC-1:0] ev, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, ev, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic rd_access(input logic [31:0] a, output logic [31:0] d);
      cycle(1'b0, '0, a, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check_eq("rd_latency_n", 32'(obs_resp), 32'h0);
      cycle(1'b0, '0, a, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check_eq("rd_resp_n1", 32'(obs_resp), 32'h1);
      d = obs_rdata;
      idle('0, 1);
      check_eq("rd_resp_once", 32'(obs_resp), 32'h0);
   endtask

   task automatic wr_access(input logic [31:0] a, input logic [31:0] wd, input logic [NC-1:0] ev);
      cycle(1'b0, ev, a, 1'b0, 1'b1, wd, 32'h0, 1'b0);
      cycle(1'b0, '0, a, 1'b0, 1'b1, wd, 32'h0, 1'b0);
      check_eq("wr_resp", 32'(obs_resp), 32'h1);
      check_eq("wr_rdata", obs_rdata, 32'h0);
      idle('0, 1);
   endtask

   initial begin
      logic [31:0] d;
      bit          act;
      bit          drop;
      logic [31:0] ha;
      logic [31:0] hwd;
      bit          hrd;
      bit          hwr;

      clk = 1'b0; rst = 1'b1; event_inc = '0; mem_addr = '0; mem_read = 1'b0;
      mem_write = 1'b0; mem_wdata = '0; rdata_b = '0; resp_b = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      cycle(1'b1, '0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

      // Reset state
      cycle(1'b0, '0, A_CTRL, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1);
      check_eq("rst_resp", 32'(obs_resp), 32'h0);
      check_eq("rst_rdata", obs_rdata, 32'h0);
      check_eq("rst_sat", 32'(obs_sat), 32'h0);
      rd_access(A_CTRL, d);
      check_eq("rst_enable", d, 32'h1);

      // 1: count dcache_hit events
      idle(12'h004, 5);
      rd_access(A_DCH, d);
      check_eq("t1_dch", d, 32'd5);

      // 2: clear wins against a same-edge event
      idle(12'h001, 7);
      rd_access(A_ICH, d);
      check_eq("t2_before", d, 32'd7);
      wr_access(A_ICH, 32'h0, 12'h001);
      rd_access(A_ICH, d);
      check_eq("t2_cleared", d, 32'd0);

      // 3: saturation of counter 4
      idle(12'h010, MAXV - 1);
      rd_access(A_L2H, d);
      check_eq("t3_near_max", d, 32'(MAXV - 1));
      idle(12'h010, 2);
      rd_access(A_L2H, d);
      check_eq("t3_max", d, 32'(MAXV));
      check_eq("t3_sat", 32'(obs_sat[4]), 32'h1);
      idle(12'h010, 1);
      rd_access(A_L2H, d);
      check_eq("t3_no_wrap", d, 32'(MAXV));

      // 4: disable, then clear-all with enable
      wr_access(A_CTRL, 32'h0, '0);
      idle(12'h002, 3);
      rd_access(A_ICM, d);
      check_eq("t4_disabled", d, 32'd0);
      rd_access(A_CTRL, d);
      check_eq("t4_ctrl0", d, 32'h0);
      wr_access(A_CTRL, 32'h3, '0);
      rd_access(A_CTRL, d);
      check_eq("t4_ctrl1", d, 32'h1);
      rd_access(A_L2H, d);
      check_eq("t4_l2h_clr", d, 32'h0);
      check_eq("t4_sat_clr", 32'(obs_sat), 32'h0);

      // 5: pass-through leaves the bank alone
      idle(12'h004, 2);
      cycle(1'b0, '0, 32'h0000_1000, 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);
      check_eq("t5_read_b", 32'(obs_read_b), 32'h1);
      check_eq("t5_resp0", 32'(obs_resp), 32'h0);
      cycle(1'b0, '0, 32'h0000_1000, 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b1);
      check_eq("t5_resp1", 32'(obs_resp), 32'h1);
      check_eq("t5_rdata", obs_rdata, 32'hCAFE_F00D);
      idle('0, 1);
      rd_access(A_DCH, d);
      check_eq("t5_dch_kept", d, 32'd2);

      // 6: reset during RESP drops the response; held read is re-accepted
      idle(12'h004, 3);
      cycle(1'b0, '0, A_DCH, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      cycle(1'b1, '0, A_DCH, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check_eq("t6_resp_in_rst", 32'(obs_resp), 32'h1);
      cycle(1'b0, '0, A_DCH, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check_eq("t6_resp_dropped", 32'(obs_resp), 32'h0);
      cycle(1'b0, '0, A_DCH, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      check_eq("t6_reaccept", 32'(obs_resp), 32'h1);
      check_eq("t6_cleared", obs_rdata, 32'h0);
      idle('0, 1);

      // Randomized traffic from a host that holds requests until mem_resp
      act = 1'b0; drop = 1'b0; ha = '0; hwd = '0; hrd = 1'b0; hwr = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         bit            r;
         logic [NC-1:0] ev;
         int            k;
         r  = ($urandom_range(0, 199) == 0);
         ev = NC'($urandom & $urandom);
         if (!act && !drop && ($urandom_range(0, 1) == 1)) begin
            act = 1'b1;
            k   = $urandom_range(0, 9);
            hwd = $urandom;
            if (k < 6) begin
               ha = 32'(TAG_LIST[$urandom_range(0, 11)]);
            end else if (k < 8) begin
               ha     = A_CTRL;
               hwd[0] = ($urandom_range(0, 3) != 0);
               hwd[1] = ($urandom_range(0, 7) == 0);
            end else if (k == 8) begin
               ha = $urandom;
               if (ha[31:8] == 24'h0) ha[31] = 1'b1;
            end else begin
               ha = 32'($urandom_range(32'h41, 32'hFF));
            end
            hwr = ($urandom_range(0, 2) == 0);
            hrd = !hwr || ($urandom_range(0, 1) == 1);
         end
         drop = 1'b0;
         if (act) cycle(r, ev, ha, hrd, hwr, hwd, $urandom, ($urandom_range(0, 3) == 0));
         else     cycle(r, ev, 32'h0, 1'b0, 1'b0, 32'h0, $urandom, ($urandom_range(0, 3) == 0));
         if (act && obs_resp) begin
            act  = 1'b0;
            drop = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
